// File: rtl/spi_slave_if_if.sv
// Strobe-style register bus between a host and the SPI slave.
// The host drives din/cmd/wr/rd; the slave answers with dout/ack/irq.
interface spi_slave_if_if;
  logic [10:0] din;
  logic        cmd;
  logic        wr;
  logic        rd;
  logic [11:0] dout;
  logic        ack;
  logic        irq;

  modport master (output din, cmd, wr, rd, input dout, ack, irq);
  modport slave  (input din, cmd, wr, rd, output dout, ack, irq);
endinterface

// File: rtl/spi_slave_if.sv
// Mode-0 SPI slave with one TX and one RX holding register behind a strobe bus.
// SPI pins are oversampled by clk, so f_clk must be at least 8x f_SCK.
module spi_slave_if #(
  parameter logic [7:0] DUMMY_BYTE = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_if_if.slave bus,
  input  logic          SPI_SCK,
  input  logic          SPI_nSS,
  input  logic          SPI_MOSI,
  output logic          SPI_MISO,
  output logic          SPI_MISO_OE
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t      state;
  logic        sck_meta, sck_s, sck_prev;
  logic        nss_meta, nss_s, nss_prev;
  logic        mosi_meta, mosi_s;
  logic        en, ie, irq_f, ovr, rxf, txe, ack_r, reload_pending;
  logic [7:0]  rx_data, tx_hold, tx_shr;
  logic [6:0]  rx_shr;
  logic [2:0]  bitcnt;
  logic        do_cmd, do_wr, do_rd, en_next;
  logic        sck_rise, sck_fall, nss_fall, oe;

  assign do_cmd   = bus.cmd;
  assign do_wr    = bus.wr & ~bus.cmd;
  assign do_rd    = bus.rd & ~bus.cmd & ~bus.wr;
  assign en_next  = bus.cmd ? bus.din[10] : en;
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign nss_fall = ~nss_s & nss_prev;

  assign oe          = en & ~nss_s;
  assign SPI_MISO_OE = oe;
  assign SPI_MISO    = oe ? tx_shr[7] : 1'b0;
  assign bus.dout    = {irq_f, ovr, rxf, txe, rx_data};
  assign bus.ack     = ack_r;
  assign bus.irq     = irq_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_meta  <= 1'b0;
      sck_s     <= 1'b0;
      sck_prev  <= 1'b0;
      nss_meta  <= 1'b1;
      nss_s     <= 1'b1;
      nss_prev  <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sck_meta  <= SPI_SCK;
      sck_s     <= sck_meta;
      sck_prev  <= sck_s;
      nss_meta  <= SPI_nSS;
      nss_s     <= nss_meta;
      nss_prev  <= nss_s;
      mosi_meta <= SPI_MOSI;
      mosi_s    <= mosi_meta;
    end
  end

  // Statement order sets same-cycle precedence: byte completion overrides
  // cmd-clear and rd, and a wr overrides the TXE set done by a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      en             <= 1'b0;
      ie             <= 1'b0;
      irq_f          <= 1'b0;
      ovr            <= 1'b0;
      rxf            <= 1'b0;
      txe            <= 1'b1;
      ack_r          <= 1'b0;
      reload_pending <= 1'b0;
      rx_data        <= 8'h00;
      tx_hold        <= 8'h00;
      tx_shr         <= 8'h00;
      rx_shr         <= 7'h00;
      bitcnt         <= 3'd0;
    end else begin
      ack_r <= bus.cmd | bus.wr | bus.rd;

      if (do_cmd) begin
        en <= bus.din[10];
        ie <= bus.din[9];
        if (bus.din[8]) begin
          irq_f <= 1'b0;
          ovr   <= 1'b0;
        end
      end
      if (do_rd)
        rxf <= 1'b0;

      if (!en_next || nss_s) begin
        state          <= IDLE;
        bitcnt         <= 3'd0;
        reload_pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (nss_fall)
              state <= LOAD;
          end
          LOAD: begin
            tx_shr <= txe ? DUMMY_BYTE : tx_hold;
            txe    <= 1'b1;
            bitcnt <= 3'd0;
            state  <= SHIFT;
          end
          SHIFT: begin
            if (sck_rise) begin
              if (bitcnt == 3'd7) begin
                rx_data        <= {rx_shr, mosi_s};
                rxf            <= 1'b1;
                bitcnt         <= 3'd0;
                reload_pending <= 1'b1;
                if (rxf && !do_rd)
                  ovr <= 1'b1;
                if (ie)
                  irq_f <= 1'b1;
              end else begin
                rx_shr <= {rx_shr[5:0], mosi_s};
                bitcnt <= bitcnt + 3'd1;
              end
            end else if (sck_fall) begin
              if (reload_pending) begin
                tx_shr         <= txe ? DUMMY_BYTE : tx_hold;
                txe            <= 1'b1;
                reload_pending <= 1'b0;
              end else begin
                tx_shr <= {tx_shr[6:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (do_wr) begin
        tx_hold <= bus.din[7:0];
        txe     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: stimulus queues expectations, one monitor
// compares on every ack, every probe request and every SCK rising edge.
module tb_spi_slave_if;

  localparam int K_NONE = 0;
  localparam int K_CMD  = 1;
  localparam int K_WR   = 2;
  localparam int K_RD   = 3;

  typedef struct {
    string      name;
    logic [13:0] val;
  } exp_t;

  logic clk;
  logic rst;
  logic spi_sck, spi_nss, spi_mosi;
  logic spi_miso, spi_miso_oe;
  logic probe, done;

  exp_t exp_q[$];
  logic miso_q[$];
  int   tests;
  int   fails;

  spi_slave_if_if bus();

  spi_slave_if #(.DUMMY_BYTE(8'hFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .SPI_SCK     (spi_sck),
    .SPI_nSS     (spi_nss),
    .SPI_MOSI    (spi_mosi),
    .SPI_MISO    (spi_miso),
    .SPI_MISO_OE (spi_miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected value layout is {irq, MISO_OE, dout}.
  logic sck_seen = 1'b0;
  logic final_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [13:0] act;
    logic b;
    if (!rst && spi_sck && !sck_seen && miso_q.size() > 0) begin
      b = miso_q.pop_front();
      tests++;
      if (spi_miso !== b) begin
        fails++;
        $display("[TB] FAIL miso_bit: got %b expected %b at %0t", spi_miso, b, $time);
      end
    end
    sck_seen = spi_sck;
    if (!rst && (bus.ack || probe)) begin
      act = {bus.irq, spi_miso_oe, bus.dout};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_output: got %h with empty scoreboard", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.val) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.val);
        end
        if (probe) begin
          tests++;
          if (bus.ack !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_ack: got %b expected 0", e.name, bus.ack);
          end
        end
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      tests++;
      if (exp_q.size() != 0 || miso_q.size() != 0) begin
        fails++;
        $display("[TB] FAIL scoreboard_drain: got %0d/%0d left expected 0/0",
                 exp_q.size(), miso_q.size());
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int kind, input logic [10:0] data,
                               input string name, input logic [13:0] exp_val);
    exp_t e;
    e.name = name;
    e.val  = exp_val;
    exp_q.push_back(e);
    bus.din = data;
    case (kind)
      K_CMD:   bus.cmd = 1'b1;
      K_WR:    bus.wr  = 1'b1;
      K_RD:    bus.rd  = 1'b1;
      default: ;
    endcase
    clks(1);
    bus.cmd = 1'b0;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    clks(1);
  endtask

  task automatic checkOutput(input string name, input logic [13:0] exp_val);
    exp_t e;
    e.name = name;
    e.val  = exp_val;
    exp_q.push_back(e);
    probe = 1'b1;
    clks(1);
    probe = 1'b0;
  endtask

  // SCK = clk/10; an optional strobe lands in the clk that completes the byte.
  task automatic spiXfer(input logic [7:0] mosi, input logic [7:0] miso_exp,
                         input int nbits, input int hook, input logic [10:0] hook_din,
                         input string hook_name, input logic [13:0] hook_exp);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = mosi[i];
      miso_q.push_back(miso_exp[i]);
      clks(5);
      spi_sck = 1'b1;
      if (i == 0 && hook != K_NONE) begin
        clks(2);
        applyStimulus(hook, hook_din, hook_name, hook_exp);
        clks(1);
      end else begin
        clks(5);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic frameStart();
    spi_nss = 1'b0;
    clks(3);
  endtask

  task automatic frameEnd();
    clks(3);
    spi_nss = 1'b1;
    clks(4);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    probe    = 1'b0;
    done     = 1'b0;
    bus.din  = 11'h000;
    bus.cmd  = 1'b0;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;
    spi_sck  = 1'b0;
    spi_nss  = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clks(2);
    checkOutput("reset", {2'b00, 12'h100});

    applyStimulus(K_CMD, 11'h600, "t1_cmd_en_ie", {2'b00, 12'h100});
    applyStimulus(K_WR, 11'h0A5, "t1_wr_a5", {2'b00, 12'h000});
    frameStart();
    spiXfer(8'h3C, 8'hA5, 8, K_NONE, 11'h000, "", 14'h0);
    checkOutput("t1_byte_done", {2'b11, 12'hB3C});
    frameEnd();
    checkOutput("t1_nss_high", {2'b10, 12'hB3C});
    applyStimulus(K_RD, 11'h000, "t1_rd", {2'b10, 12'h93C});
    applyStimulus(K_CMD, 11'h700, "t1_clear", {2'b00, 12'h13C});

    applyStimulus(K_CMD, 11'h500, "t2_cmd_no_ie", {2'b00, 12'h13C});
    frameStart();
    spiXfer(8'h81, 8'hFF, 8, K_NONE, 11'h000, "", 14'h0);
    checkOutput("t2_dummy_byte", {2'b01, 12'h381});
    frameEnd();
    applyStimulus(K_RD, 11'h000, "t2_rd", {2'b00, 12'h181});

    applyStimulus(K_WR, 11'h05A, "t3_wr_5a", {2'b00, 12'h081});
    spi_nss = 1'b0;
    clks(6);
    applyStimulus(K_WR, 11'h0C3, "t3_wr_c3", {2'b01, 12'h081});
    spiXfer(8'h11, 8'h5A, 8, K_NONE, 11'h000, "", 14'h0);
    spiXfer(8'h22, 8'hC3, 8, K_NONE, 11'h000, "", 14'h0);
    checkOutput("t3_overrun", {2'b01, 12'h722});
    frameEnd();
    applyStimulus(K_RD, 11'h000, "t3_rd", {2'b00, 12'h522});
    applyStimulus(K_CMD, 11'h500, "t3_clear", {2'b00, 12'h122});

    frameStart();
    spiXfer(8'hF0, 8'hFF, 4, K_NONE, 11'h000, "", 14'h0);
    frameEnd();
    checkOutput("t4_partial", {2'b00, 12'h122});
    frameStart();
    spiXfer(8'h96, 8'hFF, 8, K_NONE, 11'h000, "", 14'h0);
    checkOutput("t4_next_frame", {2'b01, 12'h396});
    frameEnd();
    applyStimulus(K_RD, 11'h000, "t4_rd", {2'b00, 12'h196});

    applyStimulus(K_CMD, 11'h600, "t5_cmd_ie", {2'b00, 12'h196});
    frameStart();
    spiXfer(8'h11, 8'hFF, 8, K_NONE, 11'h000, "", 14'h0);
    spiXfer(8'hC5, 8'hFF, 8, K_RD, 11'h000, "t5_rd_vs_done", {2'b11, 12'hBC5});
    spiXfer(8'h3E, 8'hFF, 8, K_CMD, 11'h700, "t5_clr_vs_done", {2'b11, 12'hF3E});
    frameEnd();
    applyStimulus(K_CMD, 11'h700, "t5_clear", {2'b00, 12'h33E});
    applyStimulus(K_RD, 11'h000, "t5_rd", {2'b00, 12'h13E});

    applyStimulus(K_CMD, 11'h600, "t6_cmd", {2'b00, 12'h13E});
    applyStimulus(K_WR, 11'h077, "t6_wr", {2'b00, 12'h03E});
    frameStart();
    spiXfer(8'hAA, 8'h77, 3, K_NONE, 11'h000, "", 14'h0);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    checkOutput("t6_after_rst", {2'b00, 12'h100});
    spiXfer(8'hFF, 8'h00, 8, K_NONE, 11'h000, "", 14'h0);
    applyStimulus(K_CMD, 11'h600, "t6_en_nss_low", {2'b01, 12'h100});
    spiXfer(8'hFF, 8'h00, 8, K_NONE, 11'h000, "", 14'h0);
    checkOutput("t6_sck_ignored", {2'b01, 12'h100});
    frameEnd();
    frameStart();
    spiXfer(8'h5A, 8'hFF, 8, K_NONE, 11'h000, "", 14'h0);
    checkOutput("t6_new_frame", {2'b11, 12'hB5A});
    frameEnd();

    done = 1'b1;
    clks(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
